// File: rtl/axis_chk_pkg.sv
// Shared types and constants for the AXI-Stream loopback packet checker.
package axis_chk_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int ERR_DATA = 0;
  localparam int ERR_KEEP = 1;
  localparam int ERR_LAST = 2;

  localparam int CNT_W = 16;

endpackage

// File: rtl/axis_ready_throttle.sv
// Rotating tready pattern: bit 0 of READY_MASK is used on the first enabled cycle,
// and the pointer then advances every enabled cycle whether or not a beat moves.
module axis_ready_throttle #(
  parameter logic [7:0] READY_MASK = 8'hFF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  input  logic clear,
  output logic ready
);

  logic [2:0] ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= 3'd0;
    end else if (clear) begin
      ptr <= 3'd0;
    end else if (enable) begin
      ptr <= ptr + 3'd1;
    end
  end

  // Built from registers only, so there is no path from the upstream tvalid.
  assign ready = enable & READY_MASK[ptr];

endmodule

// File: rtl/axis_pkt_checker.sv
// Drains the loopback FIFO under VIO control and checks each accepted beat against
// the generator's incrementing pattern, counting packets and erroneous beats.
//
// Handshake: a beat transfers on a rising clock edge where axis_tvalid and
// axis_tready are both high; data offered while axis_tready is low is ignored.
module axis_pkt_checker
  import axis_chk_pkg::*;
#(
  parameter int          DATA_WIDTH = 32,
  parameter int          PKT_LEN    = 16,
  parameter int          NUM_PKTS   = 64,
  parameter logic [7:0]  READY_MASK = 8'hFF
) (
  input  logic                    axis_aclk,
  input  logic                    axis_aresetn,
  input  logic                    start_read,
  input  logic                    axis_tvalid,
  output logic                    axis_tready,
  input  logic [DATA_WIDTH-1:0]   axis_tdata,
  input  logic [DATA_WIDTH/8-1:0] axis_tkeep,
  input  logic                    axis_tlast,
  output logic                    busy,
  output logic                    done,
  output logic [CNT_W-1:0]        pkt_cnt,
  output logic [CNT_W-1:0]        err_cnt,
  output logic [2:0]              err_flags
);

  localparam int                IDX_W      = $clog2(PKT_LEN);
  localparam logic [IDX_W-1:0]  LAST_IDX   = IDX_W'(PKT_LEN - 1);
  localparam logic [CNT_W-1:0]  PKT_TARGET = CNT_W'(NUM_PKTS);

  state_t                 state;
  logic                   start_q;
  logic [DATA_WIDTH-1:0]  exp_data;
  logic [IDX_W-1:0]       idx;
  logic                   rise;
  logic                   arm;
  logic                   in_run;
  logic                   beat;
  logic [2:0]             chk;

  assign rise   = start_read & ~start_q;
  assign in_run = (state == RUN);
  assign arm    = rise & ~in_run;
  assign beat   = axis_tvalid & axis_tready;
  assign busy   = in_run;
  assign done   = (state == DONE);

  axis_ready_throttle #(
    .READY_MASK (READY_MASK)
  ) u_throttle (
    .clk    (axis_aclk),
    .rst_n  (axis_aresetn),
    .enable (in_run),
    .clear  (arm),
    .ready  (axis_tready)
  );

  always_comb begin
    chk           = 3'b000;
    chk[ERR_DATA] = (axis_tdata != exp_data);
    chk[ERR_KEEP] = (axis_tkeep != '1);
    chk[ERR_LAST] = (axis_tlast != (idx == LAST_IDX));
  end

  always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
    if (!axis_aresetn) begin
      state     <= IDLE;
      start_q   <= 1'b0;
      exp_data  <= '0;
      idx       <= '0;
      pkt_cnt   <= '0;
      err_cnt   <= '0;
      err_flags <= 3'b000;
    end else begin
      start_q <= start_read;
      case (state)
        IDLE, DONE: begin
          if (rise) begin
            state     <= RUN;
            exp_data  <= '0;
            idx       <= '0;
            pkt_cnt   <= '0;
            err_cnt   <= '0;
            err_flags <= 3'b000;
          end
        end
        RUN: begin
          if (beat) begin
            // Expected word follows the counting sequence, so one corrupted word costs one error.
            exp_data <= exp_data + DATA_WIDTH'(1);
            if (|chk) begin
              err_flags <= err_flags | chk;
              if (err_cnt != '1) begin
                err_cnt <= err_cnt + CNT_W'(1);
              end
            end
            if (axis_tlast) begin
              idx     <= '0;
              pkt_cnt <= pkt_cnt + CNT_W'(1);
              if (pkt_cnt + CNT_W'(1) == PKT_TARGET) begin
                state <= DONE;
              end
            end else if (idx != LAST_IDX) begin
              // Index parks at the last slot so a late tlast there is not an error.
              idx <= idx + IDX_W'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
